// File: rtl/vhdci_mux_tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// vhdci_mux_tx_framer_pkg
// Shared definitions for the VHDCI mux link framer (and the future rx
// deframer): symbol geometry, idle symbol, framer state encoding, the
// chunk-XOR checksum and a saturating 16-bit increment.
// -----------------------------------------------------------------------------
package vhdci_mux_tx_framer_pkg;

   localparam int VHDCI_SYM_W      = 7;
   localparam int VHDCI_PAY_W      = 6;
   localparam int VHDCI_START_BIT  = 6;
   localparam logic [6:0] VHDCI_IDLE_SYM = 7'h00;

   // Widest word the checksum helper can fold (16 chunks).
   localparam int VHDCI_MAX_WORD_W = 96;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_WAIT = 2'd3
   } fr_state_e;

   // XOR of the lowest nsym 6-bit chunks of a zero-extended word.
   function automatic logic [5:0] chunk_xor(input logic [VHDCI_MAX_WORD_W-1:0] w,
                                            input int nsym);
      logic [5:0] x;
      x = 6'd0;
      for (int i = 0; i < VHDCI_MAX_WORD_W / VHDCI_PAY_W; i++) begin
         x = x ^ ((i < nsym) ? w[i*VHDCI_PAY_W +: VHDCI_PAY_W] : 6'd0);
      end
      return x;
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? 16'hFFFF : (v + 16'd1);
   endfunction

endpackage

// File: rtl/vhdci_mux_tx_framer_if.sv
// -----------------------------------------------------------------------------
// vhdci_mux_tx_framer_if
// Word handshake and link-side signals of the VHDCI mux tx framer.
//   word_in/word_valid/word_ready : upstream word handshake
//   mux_synced                    : link-synced status from the mux block
//   sym_out                       : 7-bit symbol towards mux_data_in
//   busy                          : frame in progress or resend pending
// master = feeder/environment side, slave = framer side.
// -----------------------------------------------------------------------------
interface vhdci_mux_tx_framer_if #(
   parameter int WORD_W = 24
);
   logic [WORD_W-1:0] word_in;
   logic              word_valid;
   logic              word_ready;
   logic              mux_synced;
   logic [6:0]        sym_out;
   logic              busy;

   modport master (
      output word_in, word_valid, mux_synced,
      input  word_ready, sym_out, busy
   );

   modport slave (
      input  word_in, word_valid, mux_synced,
      output word_ready, sym_out, busy
   );
endinterface

// File: rtl/vhdci_mux_tx_framer.sv
// -----------------------------------------------------------------------------
// vhdci_mux_tx_framer
// Frames WORD_W-bit words into 7-bit symbols for the VHDCI mux link:
// header symbol (start flag set, top 6 bits), remaining 6-bit chunks MSB
// first, then the XOR of all chunks. Transmits only while mux_synced is
// high; a frame cut by sync loss is resent from its header after re-sync.
// Runs in the clk_mux_div domain.
// Ports:
//   clk_in       symbol clock
//   rst_n_in     asynchronous reset, active low
//   bus (slave)  word_in/word_valid/word_ready, mux_synced, sym_out, busy
//   frame_count  frames completed, saturating  (VHDCI_FRAMER_STATS_EN only)
//   abort_count  frames aborted, saturating    (VHDCI_FRAMER_STATS_EN only)
// Optional feature macro: VHDCI_FRAMER_STATS_EN
// -----------------------------------------------------------------------------
module vhdci_mux_tx_framer
   import vhdci_mux_tx_framer_pkg::*;
#(
   parameter int WORD_W   = 24,
   parameter int IDLE_GAP = 1
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   vhdci_mux_tx_framer_if.slave bus
`ifdef VHDCI_FRAMER_STATS_EN
   ,
   output logic [15:0]          frame_count,
   output logic [15:0]          abort_count
`endif
);

   localparam int NSYM  = WORD_W / VHDCI_PAY_W;
   localparam int IDX_W = $clog2(NSYM + 1);

   if (((WORD_W % VHDCI_PAY_W) != 0) || (WORD_W < VHDCI_PAY_W) ||
       (WORD_W > VHDCI_MAX_WORD_W)) begin : g_bad_word_w
      $error("vhdci_mux_tx_framer: WORD_W must be a multiple of 6 in 6..96");
   end
   if ((IDLE_GAP < 0) || (IDLE_GAP > 15)) begin : g_bad_gap
      $error("vhdci_mux_tx_framer: IDLE_GAP must be 0..15");
   end

   fr_state_e                   state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [3:0]                  gap_q, gap_d;
   logic [WORD_W-1:0]           hold_q, hold_d;
   logic [5:0]                  csum_q, csum_d;
   logic [6:0]                  sym_q, sym_d;

   logic                        accept_s;
   logic [5:0]                  pay_s;
   logic [VHDCI_MAX_WORD_W-1:0] word_ext_s;

   // Ready is held low while reset is asserted even though state reads IDLE.
   assign bus.word_ready = (state_q == ST_IDLE) && bus.mux_synced && rst_n_in;
   assign accept_s       = bus.word_valid && bus.word_ready;
   assign bus.sym_out    = sym_q;
   assign bus.busy       = (state_q == ST_SEND) || (state_q == ST_WAIT);

   // Zero-extend the incoming word for the shared checksum helper.
   always_comb begin
      word_ext_s               = '0;
      word_ext_s[WORD_W-1:0]   = bus.word_in;
   end

   // Select the held 6-bit chunk addressed by the symbol index (0 = MSB chunk).
   always_comb begin
      pay_s = 6'd0;
      for (int k = 0; k < NSYM; k++) begin
         pay_s = pay_s | ((idx_q == IDX_W'(k)) ?
                          hold_q[WORD_W-1-k*VHDCI_PAY_W -: VHDCI_PAY_W] : 6'd0);
      end
   end

   // Framer next-state and next-symbol logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      hold_d  = hold_q;
      csum_d  = csum_q;
      sym_d   = VHDCI_IDLE_SYM;

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               // Header goes out on the accept edge itself, so the next
               // symbol to send is chunk 1.
               hold_d  = bus.word_in;
               csum_d  = chunk_xor(word_ext_s, NSYM);
               sym_d   = {1'b1, bus.word_in[WORD_W-1 -: VHDCI_PAY_W]};
               idx_d   = IDX_W'(1);
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SEND: begin
            if (!bus.mux_synced) begin
               // Abort: emit idle and rewind to the header for the resend.
               idx_d   = '0;
               state_d = ST_WAIT;
            end else if (idx_q == IDX_W'(NSYM)) begin
               sym_d = {1'b0, csum_q};
               idx_d = '0;
               if (IDLE_GAP > 0) begin
                  gap_d   = 4'(IDLE_GAP);
                  state_d = ST_GAP;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               // Index 0 only occurs on a resend, where the header is rebuilt.
               sym_d = {(idx_q == '0), pay_s};
               idx_d = idx_q + IDX_W'(1);
            end
         end

         ST_GAP: begin
            // Countdown runs regardless of link sync.
            if (gap_q <= 4'd1) begin
               gap_d   = 4'd0;
               state_d = ST_IDLE;
            end else begin
               gap_d   = gap_q - 4'd1;
            end
         end

         ST_WAIT: begin
            if (bus.mux_synced) begin
               idx_d   = '0;
               state_d = ST_SEND;
            end else begin
               state_d = ST_WAIT;
            end
         end

         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            gap_d   = 4'd0;
         end
      endcase
   end

   // Framer state, hold register and registered symbol output.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         gap_q   <= 4'd0;
         hold_q  <= '0;
         csum_q  <= 6'd0;
         sym_q   <= VHDCI_IDLE_SYM;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         hold_q  <= hold_d;
         csum_q  <= csum_d;
         sym_q   <= sym_d;
      end
   end

`ifdef VHDCI_FRAMER_STATS_EN
   logic        frame_inc_s, abort_inc_s;
   logic [15:0] frame_count_q, frame_count_d;
   logic [15:0] abort_count_q, abort_count_d;

   // A frame completes when its checksum goes out with the link synced;
   // any SEND edge with the link down is an abort.
   always_comb begin
      frame_inc_s   = (state_q == ST_SEND) && bus.mux_synced && (idx_q == IDX_W'(NSYM));
      abort_inc_s   = (state_q == ST_SEND) && !bus.mux_synced;
      frame_count_d = frame_inc_s ? sat_inc16(frame_count_q) : frame_count_q;
      abort_count_d = abort_inc_s ? sat_inc16(abort_count_q) : abort_count_q;
   end

   // Saturating statistics counters.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         frame_count_q <= 16'd0;
         abort_count_q <= 16'd0;
      end else begin
         frame_count_q <= frame_count_d;
         abort_count_q <= abort_count_d;
      end
   end

   assign frame_count = frame_count_q;
   assign abort_count = abort_count_q;
`else
`endif

endmodule
